// File: rtl/temporizador.sv
// Keypad-loaded countdown timer. It keeps the remaining time as three BCD digits
// (minutes, tens of seconds, units of seconds) and steps down once per TICK_DIV clocks.
module temporizador #(
  parameter int unsigned TICK_DIV = 50000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] data,
  input  logic       load,
  input  logic       enable,
  output logic [3:0] mins,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       zero,
  output logic       done
);

  localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  logic [3:0]    mins_q, mins_d;
  logic [3:0]    tens_q, tens_d;
  logic [3:0]    ones_q, ones_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          done_q, done_d;

  logic [3:0] ones_step, tens_step, mins_step;
  logic       borrow_tens, borrow_mins;

  assign zero = (mins_q == 4'd0) && (tens_q == 4'd0) && (ones_q == 4'd0);

  // Borrow chain for one countdown step. Tens values above 5 are legal from keyed
  // entry and simply count down until they reach 0.
  always_comb begin
    borrow_tens = (ones_q == 4'd0);
    borrow_mins = borrow_tens && (tens_q == 4'd0);
    ones_step   = borrow_tens ? 4'd9 : ones_q - 4'd1;
    tens_step   = tens_q;
    if (borrow_tens) begin
      tens_step = (tens_q == 4'd0) ? 4'd5 : tens_q - 4'd1;
    end
    mins_step = borrow_mins ? mins_q - 4'd1 : mins_q;
  end

  always_comb begin
    mins_d  = mins_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    presc_d = '0;
    done_d  = 1'b0;
    if (load) begin
      if (data <= 4'd9) begin
        mins_d = tens_q;
        tens_d = ones_q;
        ones_d = data;
      end
    end else if (enable && !zero) begin
      if (presc_q == PRESC_MAX) begin
        mins_d = mins_step;
        tens_d = tens_step;
        ones_d = ones_step;
        done_d = (mins_step == 4'd0) && (tens_step == 4'd0) && (ones_step == 4'd0);
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mins_q  <= 4'd0;
      tens_q  <= 4'd0;
      ones_q  <= 4'd0;
      presc_q <= '0;
      done_q  <= 1'b0;
    end else begin
      mins_q  <= mins_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      presc_q <= presc_d;
      done_q  <= done_d;
    end
  end

  assign mins     = mins_q;
  assign sec_tens = tens_q;
  assign sec_ones = ones_q;
  assign done     = done_q;

endmodule
